add4b: RTL and testbench

- 4-bit carry-lookahead adder slice with registered outputs.
- Adds ai + bi + C0 and produces a 4-bit sum plus group propagate (GP) and group generate (GG) signals.
- Intended as the building block of a 16/32-bit two-level CLA adder, where an upper lookahead unit combines GP/GG.
- No carry-out port; the upper level forms the slice carry-out as GG | (GP & C0).

---
 rtl/add4b.sv | 57 +++++
 tb/tb_add4b.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/add4b.sv
// 4-bit carry-lookahead adder slice with registered sum and group propagate/generate.
// Slice carry-out is left to the upper lookahead level: GG | (GP & C0).
module add4b (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ai,
  input  logic [3:0] bi,
  input  logic       C0,
  output logic [3:0] s,
  output logic       GP,
  output logic       GG
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;
  logic [3:0] s_d;
  logic [3:0] s_q;
  logic       gp_d;
  logic       gp_q;
  logic       gg_d;
  logic       gg_q;

  // XOR propagate lets the sum reuse p, and keeps GP and GG mutually exclusive.
  always_comb begin
    g = ai & bi;
    p = ai ^ bi;

    c[0] = C0;
    c[1] = g[0] | (p[0] & C0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & C0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & C0);

    s_d  = p ^ c;
    gp_d = p[3] & p[2] & p[1] & p[0];
    gg_d = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q  <= 4'b0000;
      gp_q <= 1'b0;
      gg_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      gp_q <= gp_d;
      gg_q <= gg_d;
    end
  end

  assign s  = s_q;
  assign GP = gp_q;
  assign GG = gg_q;

endmodule

// File: tb/tb_add4b.sv
// Directed and exhaustive checks of the add4b registered CLA slice.
module tb_add4b;

  logic       clk;
  logic       rst_n;
  logic [3:0] ai;
  logic [3:0] bi;
  logic       C0;
  logic [3:0] s;
  logic       GP;
  logic       GG;

  int n_cmp;
  int n_err;

  // {chk, c0, s[3:0], gp, gg, cout}
  logic [8:0] exp_q[$];

  add4b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ai    (ai),
    .bi    (bi),
    .C0    (C0),
    .s     (s),
    .GP    (GP),
    .GG    (GG)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c);
    ai = a;
    bi = b;
    C0 = c;
  endtask

  task automatic check_out(input string name, input logic [3:0] es, input logic egp,
                           input logic egg);
    n_cmp++;
    if (s !== es) begin
      n_err++;
      $display("FAIL %s.s: got %0d expected %0d", name, s, es);
    end
    n_cmp++;
    if (GP !== egp) begin
      n_err++;
      $display("FAIL %s.GP: got %b expected %b", name, GP, egp);
    end
    n_cmp++;
    if (GG !== egg) begin
      n_err++;
      $display("FAIL %s.GG: got %b expected %b", name, GG, egg);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    drive(4'd15, 4'd15, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_out("reset_async", 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_out("reset_hold", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("reset_release", 4'd15, 1'b0, 1'b1);
  endtask

  task automatic test_basic;
    logic [3:0] ta [4]  = '{4'd5, 4'd8, 4'd10, 4'd10};
    logic [3:0] tb [4]  = '{4'd3, 4'd8, 4'd5, 4'd5};
    logic       tc [4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] es [4]  = '{4'd8, 4'd0, 4'd15, 4'd0};
    logic       egp [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       egg [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(ta[i], tb[i], tc[i]);
      @(posedge clk);
      #1;
      check_out($sformatf("basic%0d", i), es[i], egp[i], egg[i]);
    end
    // implied carry-out for 10+5+1
    n_cmp++;
    if ((GG | (GP & C0)) !== 1'b1) begin
      n_err++;
      $display("FAIL basic_cout: got %b expected 1", GG | (GP & C0));
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] ta [3]  = '{4'd1, 4'd7, 4'd0};
    logic [3:0] tb [3]  = '{4'd1, 4'd9, 4'd0};
    logic [3:0] es [3]  = '{4'd2, 4'd0, 4'd0};
    logic       egg [3] = '{1'b0, 1'b1, 1'b0};
    @(negedge clk);
    drive(ta[0], tb[0], 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_out($sformatf("pipe%0d", i), es[i], 1'b0, egg[i]);
      if (i < 2) drive(ta[i+1], tb[i+1], 1'b0);
    end
  endtask

  task automatic check_entry(input logic [8:0] e, input int idx);
    if (e[8]) begin
      check_out($sformatf("sweep%0d", idx), e[6:3], e[2], e[1]);
      n_cmp++;
      if ((GG | (GP & e[7])) !== e[0]) begin
        n_err++;
        $display("FAIL sweep%0d.cout: got %b expected %b", idx, GG | (GP & e[7]), e[0]);
      end
      n_cmp++;
      if ((GP & GG) !== 1'b0) begin
        n_err++;
        $display("FAIL sweep%0d.gp_and_gg: got %b expected 0", idx, GP & GG);
      end
    end
  endtask

  // Exhaustive sweep with a reset pulse mid-stream; the vector hit by the
  // pulse is re-applied right after so the sweep stays complete.
  task automatic test_sweep;
    int         v;
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [4:0] sum;
    logic [4:0] gsum;
    logic [8:0] e;
    for (int idx = 0; idx <= 512; idx++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_entry(e, idx - 1);
      end
      v = (idx > 300) ? idx - 1 : idx;
      a = v[8:5];
      b = v[4:1];
      c = v[0];
      drive(a, b, c);
      sum  = {1'b0, a} + {1'b0, b} + {4'b0, c};
      gsum = {1'b0, a} + {1'b0, b};
      e = {1'b1, c, sum[3:0], (a ^ b) == 4'hf, gsum[4], sum[4]};
      if (idx == 300) begin
        #1;
        rst_n = 1'b0;
        #1;
        check_out("mid_reset", 4'd0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        e[8] = 1'b0;
      end
      exp_q.push_back(e);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    check_entry(e, 512);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b1;
    drive(4'd0, 4'd0, 1'b0);
    test_reset();
    test_basic();
    test_back_to_back();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
